ulpi_link_rx: RTL and testbench

// - ULPI link-layer front end between the ULPI IO buffers and the sniffer capture core, on the 60MHz PHY clock.
// - After reset, writes the PHY Function Control register to non-driving (sniff) mode.
// - Decodes PHY-driven bus cycles into a packet byte stream (SOP/EOP/error) plus RX CMD line status.

---
 rtl/ulpi_link_rx.sv | 225 ++++++++++++++++++++++
 tb/tb_ulpi_link_rx.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ulpi_link_rx.sv
// ulpi_link_rx
// ULPI link-layer receive front end running on the 60MHz PHY clock.
// After reset it writes the PHY Function Control register to put the PHY
// into non-driving (sniff) mode. It then decodes PHY-driven bus cycles into
// a packet byte stream with SOP/EOP/error qualifiers and tracks RX CMD line
// status.
//
// Ports
//   clk_i          ULPI PHY clock, all logic on the rising edge
//   rst_ni         asynchronous active-low reset
//   ulpi_data_i    bus data from the PHY
//   ulpi_data_o    bus data to the PHY (pad tristates while dir=1)
//   ulpi_dir_i     1 = PHY owns the bus
//   ulpi_nxt_i     PHY nxt
//   ulpi_stp_o     link stp
//   xcvr_sel_i     XcvrSelect, merged into the Function Control value
//   mode_update_i  pulse requesting a fresh Function Control write
//   cfg_done_o     latest Function Control write has completed
//   rx_valid_o     packet byte strobe, rx_data_o holds the byte
//   rx_sop_o       first byte of a packet (with rx_valid_o)
//   rx_eop_o       end-of-packet strobe, rx_err_o flags a bad packet
//   linestate_o    LineState from the last RX CMD
//   vbus_o         VbusState from the last RX CMD
module ulpi_link_rx #(
  parameter logic [5:0] FC_ADDR = 6'h04,
  parameter logic [7:0] FC_BASE = 8'h48
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] ulpi_data_i,
  output logic [7:0] ulpi_data_o,
  input  logic       ulpi_dir_i,
  input  logic       ulpi_nxt_i,
  output logic       ulpi_stp_o,
  input  logic [1:0] xcvr_sel_i,
  input  logic       mode_update_i,
  output logic       cfg_done_o,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  output logic       rx_sop_o,
  output logic       rx_eop_o,
  output logic       rx_err_o,
  output logic [1:0] linestate_o,
  output logic [1:0] vbus_o
);

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_CMD  = 2'd1,
    TX_DATA = 2'd2,
    TX_STP  = 2'd3
  } tx_state_t;

  tx_state_t  tx_state;
  tx_state_t  tx_next;
  logic [7:0] tx_data;
  logic       start_write;

  logic       prev_dir;
  logic       turnaround;
  logic       dir_fall;

  logic       stp_boot;     // stp held high from reset until the first clock
  logic       cfg_pending;
  logic       rewrite;      // mode update seen while a write was in flight
  logic [1:0] xcvr_lat;

  logic       rx_active;
  logic       in_pkt;
  logic       first_byte;
  logic       sticky_err;
  logic       cmd_active;
  logic       cmd_err;

  // ---------------------------------------------------------------------------
  // Bus ownership tracking
  // ---------------------------------------------------------------------------
  always_comb begin
    turnaround = ulpi_dir_i ^ prev_dir;
    dir_fall   = prev_dir & ~ulpi_dir_i;
    // RxEvent is data[5:4]; codes 01 and 11 both mean RxActive, 11 adds RxError
    cmd_active = ulpi_data_i[4];
    cmd_err    = ulpi_data_i[5] & ulpi_data_i[4];
  end

  // ---------------------------------------------------------------------------
  // TX register-write FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_next     = tx_state;
    tx_data     = '0;
    start_write = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (cfg_pending && !ulpi_dir_i && !prev_dir) begin
          tx_next     = TX_CMD;
          start_write = 1'b1;
        end
      end
      TX_CMD: begin
        tx_data = {2'b10, FC_ADDR};
        if (ulpi_dir_i) begin
          tx_next = TX_IDLE;
        end else if (ulpi_nxt_i) begin
          tx_next = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_data = FC_BASE | {6'b0, xcvr_lat};
        if (ulpi_dir_i) begin
          tx_next = TX_IDLE;
        end else if (ulpi_nxt_i) begin
          tx_next = TX_STP;
        end
      end
      TX_STP: begin
        tx_next = TX_IDLE;
      end
      default: begin
        tx_next = TX_IDLE;
      end
    endcase
  end

  always_comb begin
    // Data is forced to zero the moment the PHY takes the bus so an aborted
    // write never presents a driven value during dir=1.
    ulpi_data_o = ulpi_dir_i ? '0 : tx_data;
    ulpi_stp_o  = stp_boot | (tx_state == TX_STP);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state    <= TX_IDLE;
      stp_boot    <= 1'b1;
      cfg_pending <= 1'b1;
      rewrite     <= 1'b0;
      xcvr_lat    <= '0;
      cfg_done_o  <= 1'b0;
    end else begin
      tx_state <= tx_next;
      stp_boot <= 1'b0;

      if (start_write) begin
        xcvr_lat <= xcvr_sel_i;
        rewrite  <= 1'b0;
      end else if (mode_update_i && tx_state != TX_IDLE) begin
        rewrite <= 1'b1;
      end

      // A request that arrived during the current write keeps the pending
      // flag alive so exactly one further write follows this one.
      if (mode_update_i) begin
        cfg_pending <= 1'b1;
        cfg_done_o  <= 1'b0;
      end else if (tx_state == TX_STP && !rewrite) begin
        cfg_pending <= 1'b0;
        cfg_done_o  <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RX decode
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_dir    <= 1'b0;
      rx_active   <= 1'b0;
      in_pkt      <= 1'b0;
      first_byte  <= 1'b0;
      sticky_err  <= 1'b0;
      rx_valid_o  <= 1'b0;
      rx_data_o   <= '0;
      rx_sop_o    <= 1'b0;
      rx_eop_o    <= 1'b0;
      rx_err_o    <= 1'b0;
      linestate_o <= '0;
      vbus_o      <= '0;
    end else begin
      prev_dir   <= ulpi_dir_i;
      rx_valid_o <= 1'b0;
      rx_sop_o   <= 1'b0;
      rx_eop_o   <= 1'b0;
      rx_err_o   <= 1'b0;

      if (ulpi_dir_i && !turnaround) begin
        if (!ulpi_nxt_i) begin
          // RX CMD
          linestate_o <= ulpi_data_i[1:0];
          vbus_o      <= ulpi_data_i[3:2];
          rx_active   <= cmd_active;
          if (!rx_active && cmd_active) begin
            in_pkt     <= 1'b1;
            first_byte <= 1'b1;
          end
          if (rx_active && !cmd_active && in_pkt) begin
            in_pkt     <= 1'b0;
            rx_eop_o   <= 1'b1;
            rx_err_o   <= sticky_err;
            sticky_err <= 1'b0;
          end else if (cmd_err) begin
            sticky_err <= 1'b1;
          end
        end else if (in_pkt) begin
          rx_valid_o <= 1'b1;
          rx_data_o  <= ulpi_data_i;
          rx_sop_o   <= first_byte;
          first_byte <= 1'b0;
        end
      end else if (dir_fall) begin
        // Releasing the bus ends any receive; RxActive is dropped too so the
        // next RX CMD with RxActive=1 opens a fresh packet.
        rx_active <= 1'b0;
        if (in_pkt) begin
          in_pkt     <= 1'b0;
          rx_eop_o   <= 1'b1;
          rx_err_o   <= sticky_err | rx_active;
          sticky_err <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ulpi_link_rx.sv
// Testbench for ulpi_link_rx: drives PHY-side bus cycles and checks the
// Function Control write handshake and the decoded packet stream. Packet
// transactions push their expected byte/EOP events into a scoreboard queue;
// a monitor pops and compares them as the DUT presents outputs.
module tb_ulpi_link_rx;

  logic       clk;
  logic       rst_n;
  logic [7:0] ulpi_data_i;
  logic [7:0] ulpi_data_o;
  logic       ulpi_dir;
  logic       ulpi_nxt;
  logic       ulpi_stp;
  logic [1:0] xcvr_sel;
  logic       mode_update;
  logic       cfg_done;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_sop;
  logic       rx_eop;
  logic       rx_err;
  logic [1:0] linestate;
  logic [1:0] vbus;

  ulpi_link_rx #(.FC_ADDR(6'h04), .FC_BASE(8'h48)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .ulpi_data_i   (ulpi_data_i),
    .ulpi_data_o   (ulpi_data_o),
    .ulpi_dir_i    (ulpi_dir),
    .ulpi_nxt_i    (ulpi_nxt),
    .ulpi_stp_o    (ulpi_stp),
    .xcvr_sel_i    (xcvr_sel),
    .mode_update_i (mode_update),
    .cfg_done_o    (cfg_done),
    .rx_valid_o    (rx_valid),
    .rx_data_o     (rx_data),
    .rx_sop_o      (rx_sop),
    .rx_eop_o      (rx_eop),
    .rx_err_o      (rx_err),
    .linestate_o   (linestate),
    .vbus_o        (vbus)
  );

  initial clk = 1'b0;
  always #8 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       eop;
    logic       err;
    logic       sop;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       expq[$];
  exp_t       mon_e;
  logic [7:0] pkt[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One bus cycle: inputs change just after a rising edge, DUT samples them
  // at the next rising edge.
  task automatic drive(input logic d, input logic n, input logic [7:0] x);
    ulpi_dir    = d;
    ulpi_nxt    = n;
    ulpi_data_i = x;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_byte(input logic [7:0] b, input logic sop);
    expq.push_back('{eop: 1'b0, err: 1'b0, sop: sop, data: b, due: cyc + 1});
  endtask

  task automatic expect_eop(input logic err);
    expq.push_back('{eop: 1'b1, err: err, sop: 1'b0, data: 8'h00, due: cyc + 1});
  endtask

  // RX CMD cycle (bus already owned by PHY); line status follows one clock later.
  task automatic rx_cmd(input logic [7:0] c);
    drive(1'b1, 1'b0, c);
    check("linestate", 32'(linestate), 32'(c[1:0]));
    check("vbus", 32'(vbus), 32'(c[3:2]));
  endtask

  // Packet transaction: turnaround, RX CMD opening the packet, the bytes in
  // pkt[], then an end by RX CMD (mode 0/1) or by dir dropping (mode 2).
  // Mode 1 inserts RX CMD 8'h30 (RxError) after byte err_at.
  task automatic rx_packet(input logic [7:0] start_cmd, input int mode, input int err_at,
                           input bit fill);
    bit         sticky;
    logic [7:0] c;
    drive(1'b1, 1'($urandom), 8'($urandom));
    if (fill && $urandom_range(0, 1) == 1)
      rx_cmd({2'($urandom), ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00, 4'($urandom)});
    if (fill && $urandom_range(0, 1) == 1) begin
      drive(1'b1, 1'b1, 8'($urandom));
      check("stray_byte_dropped", 32'(rx_valid), 32'd0);
    end
    sticky = (start_cmd[5:4] == 2'b11);
    rx_cmd(start_cmd);
    for (int i = 0; i < pkt.size(); i++) begin
      expect_byte(pkt[i], i == 0);
      drive(1'b1, 1'b1, pkt[i]);
      if (mode == 1 && i == err_at) begin
        rx_cmd(8'h30);
        sticky = 1'b1;
      end else if (fill && $urandom_range(0, 3) == 0) begin
        c = {2'($urandom), ($urandom_range(0, 2) == 0) ? 2'b11 : 2'b01, 4'($urandom)};
        if (c[5:4] == 2'b11) sticky = 1'b1;
        rx_cmd(c);
      end
    end
    if (mode == 2) begin
      expect_eop(1'b1);
      drive(1'b0, 1'b0, 8'h00);
    end else begin
      expect_eop(sticky);
      c = fill ? {2'($urandom), ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00, 4'($urandom)}
               : 8'h00;
      rx_cmd(c);
      drive(1'b0, 1'b0, 8'h00);
    end
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic wait_txcmd();
    int n = 0;
    while (ulpi_data_o !== 8'h84 && n < 20) begin
      drive(1'b0, 1'b0, 8'h00);
      n++;
    end
    check("txcmd_seen", 32'(ulpi_data_o), 32'h84);
  endtask

  // PHY side of one Function Control write with random nxt wait states.
  task automatic phy_write(input logic [7:0] exp_fc, input bit pulse_in_stp);
    wait_txcmd();
    repeat ($urandom_range(0, 3)) begin
      drive(1'b0, 1'b0, 8'h00);
      check("txcmd_hold", 32'(ulpi_data_o), 32'h84);
      check("stp_low_cmd", 32'(ulpi_stp), 32'd0);
    end
    drive(1'b0, 1'b1, 8'h00);
    check("fc_data", 32'(ulpi_data_o), 32'(exp_fc));
    repeat ($urandom_range(0, 3)) begin
      drive(1'b0, 1'b0, 8'h00);
      check("fc_hold", 32'(ulpi_data_o), 32'(exp_fc));
    end
    drive(1'b0, 1'b1, 8'h00);
    check("stp_high", 32'(ulpi_stp), 32'd1);
    check("stp_data", 32'(ulpi_data_o), 32'd0);
    check("done_before_stp", 32'(cfg_done), 32'd0);
    if (pulse_in_stp) begin
      mode_update = 1'b1;
      drive(1'b0, 1'b0, 8'h00);
      mode_update = 1'b0;
      check("stp_low", 32'(ulpi_stp), 32'd0);
      check("done_after_pulse", 32'(cfg_done), 32'd0);
    end else begin
      drive(1'b0, 1'b0, 8'h00);
      check("stp_low", 32'(ulpi_stp), 32'd0);
      check("cfg_done", 32'(cfg_done), 32'd1);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ulpi_dir) check("bus_released", 32'(ulpi_data_o), 32'd0);
      if (rx_valid || rx_eop) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rx valid=%0b eop=%0b data=%02h, none expected (cycle %0d)",
                   rx_valid, rx_eop, rx_data, cyc);
        end else begin
          mon_e = expq.pop_front();
          check("rx_latency", 32'(cyc), 32'(mon_e.due));
          check("rx_kind_eop", 32'(rx_eop), 32'(mon_e.eop));
          if (mon_e.eop) begin
            check("rx_err", 32'(rx_err), 32'(mon_e.err));
            check("eop_alone", 32'(rx_valid), 32'd0);
          end else begin
            check("rx_data", 32'(rx_data), 32'(mon_e.data));
            check("rx_sop", 32'(rx_sop), 32'(mon_e.sop));
          end
        end
      end else begin
        check("qualifiers_idle", 32'({rx_sop, rx_err}), 32'd0);
        if (expq.size() != 0 && expq[0].due <= cyc) begin
          mon_e = expq.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_rx eop=%0b data=%02h due %0d got nothing (cycle %0d)",
                   mon_e.eop, mon_e.data, mon_e.due, cyc);
        end
      end
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    ulpi_dir    = 1'b0;
    ulpi_nxt    = 1'b0;
    ulpi_data_i = 8'h00;
    xcvr_sel    = 2'b00;
    mode_update = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stp", 32'(ulpi_stp), 32'd1);
    check("rst_data", 32'(ulpi_data_o), 32'd0);
    check("rst_cfg_done", 32'(cfg_done), 32'd0);
    check("rst_rx", 32'({rx_valid, rx_sop, rx_eop, rx_err}), 32'd0);
    check("rst_status", 32'({linestate, vbus}), 32'd0);
    rst_n = 1'b1;

    // Boot-time write: stp drops and the TX CMD appears on the first clock.
    drive(1'b0, 1'b0, 8'h00);
    check("boot_stp_low", 32'(ulpi_stp), 32'd0);
    check("boot_txcmd", 32'(ulpi_data_o), 32'h84);
    phy_write(8'h48, 1'b0);

    // Directed packets: normal end, RxError mid-packet, dir dropping.
    for (int m = 0; m < 3; m++) begin
      pkt.delete();
      pkt.push_back(8'hA5);
      pkt.push_back(8'hC3);
      pkt.push_back(8'h5A);
      rx_packet(8'h10, m, 0, 1'b0);
    end

    // Idle RX CMD and a stray data byte outside any packet.
    drive(1'b1, 1'b0, 8'hFF);
    rx_cmd(8'h0E);
    drive(1'b1, 1'b1, 8'h77);
    check("stray_no_valid", 32'(rx_valid), 32'd0);
    rx_cmd(8'h0E);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);

    // Write aborted by dir in DATA, then retried once dir has been low twice.
    xcvr_sel    = 2'b01;
    mode_update = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    mode_update = 1'b0;
    check("update_clears_done", 32'(cfg_done), 32'd0);
    wait_txcmd();
    drive(1'b0, 1'b1, 8'h00);
    check("abort_fc_data", 32'(ulpi_data_o), 32'h49);
    ulpi_dir = 1'b1;
    #1;
    check("abort_bus_zero", 32'(ulpi_data_o), 32'd0);
    drive(1'b1, 1'b0, 8'h00);
    check("abort_stp", 32'(ulpi_stp), 32'd0);
    rx_cmd(8'h00);
    drive(1'b0, 1'b0, 8'h00);
    check("retry_wait", 32'(ulpi_data_o), 32'd0);
    drive(1'b0, 1'b0, 8'h00);
    check("retry_txcmd", 32'(ulpi_data_o), 32'h84);
    check("retry_pending_done", 32'(cfg_done), 32'd0);
    phy_write(8'h49, 1'b0);

    // mode_update during STP forces exactly one further write.
    xcvr_sel    = 2'b00;
    mode_update = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    mode_update = 1'b0;
    phy_write(8'h48, 1'b1);
    phy_write(8'h48, 1'b0);
    repeat (6) begin
      drive(1'b0, 1'b0, 8'h00);
      check("no_extra_write", 32'({ulpi_stp, ulpi_data_o}), 32'd0);
      check("done_stays", 32'(cfg_done), 32'd1);
    end

    // Randomized packets.
    for (int k = 0; k < 30; k++) begin
      int n;
      pkt.delete();
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
      rx_packet({2'($urandom), ($urandom_range(0, 4) == 0) ? 2'b11 : 2'b01, 4'($urandom)},
                int'($urandom_range(0, 2)), int'($urandom_range(0, n - 1)), 1'b1);
      repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 8'h00);
    end

    // Asynchronous reset in the middle of a write, then a fresh write.
    mode_update = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    mode_update = 1'b0;
    wait_txcmd();
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_stp", 32'(ulpi_stp), 32'd1);
    check("midrst_data", 32'(ulpi_data_o), 32'd0);
    check("midrst_status", 32'({cfg_done, linestate, vbus}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    check("midrst_txcmd", 32'(ulpi_data_o), 32'h84);
    phy_write(8'h48, 1'b0);

    repeat (4) drive(1'b0, 1'b0, 8'h00);
    check("queue_drained", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
